// File: rtl/hazard_pkg.sv
// Shared hazard-detection constants: Tuse/Tnew codes, register-zero index and
// default mult/div latencies used by stall_ctrl and md_busy_timer.
package hazard_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    localparam logic [4:0] REG_ZERO  = 5'd0;

    localparam int MULT_CYC_DFLT = 5;
    localparam int DIV_CYC_DFLT  = 10;

    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy timer: IDLE/BUSY FSM with a down-counter loaded on md_start.
// md_busy is high while the counter is non-zero.
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DFLT,
    parameter int DIV_CYC  = DIV_CYC_DFLT,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_is_div,
    output logic md_busy
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (md_start) begin
                    state_d = MD_BUSY;
                    cnt_d   = md_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
                end
            end
            MD_BUSY: begin
                // A second md_start while busy is a protocol error and is ignored.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments and async reset so md_busy drops at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy = (cnt_q != '0);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: D-stage RAW hazards (Tuse/Tnew) plus mult/div busy.
// Optional STALL_STAT_EN adds a saturating stall_cnt output.
module stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DFLT,
    parameter int DIV_CYC  = DIV_CYC_DFLT,
    parameter int CNT_W    = 4
`ifdef STALL_STAT_EN
    ,
    parameter int STAT_W   = 32
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [1:0] id_tuse_rs,
    input  logic [1:0] id_tuse_rt,
    input  logic       id_is_md,
    input  logic [4:0] ex_wreg,
    input  logic [1:0] ex_tnew,
    input  logic [4:0] mem_wreg,
    input  logic [1:0] mem_tnew,
    input  logic       md_start,
    input  logic       md_is_div,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_clr,
    output logic       md_busy
`ifdef STALL_STAT_EN
    ,
    output logic [STAT_W-1:0] stall_cnt
`endif
);

    logic rs_stall, rt_stall, md_stall, stall;

    // Equal Tnew/Tuse is covered by forwarding, hence strict greater-than.
    assign rs_stall = (id_rs != REG_ZERO) &&
                      (((id_rs == ex_wreg)  && (ex_tnew  > id_tuse_rs)) ||
                       ((id_rs == mem_wreg) && (mem_tnew > id_tuse_rs)));
    assign rt_stall = (id_rt != REG_ZERO) &&
                      (((id_rt == ex_wreg)  && (ex_tnew  > id_tuse_rt)) ||
                       ((id_rt == mem_wreg) && (mem_tnew > id_tuse_rt)));
    assign md_stall = id_is_md && (md_start || md_busy);
    assign stall    = rs_stall || rt_stall || md_stall;

    assign pc_en    = ~stall;
    assign ifid_en  = ~stall;
    assign idex_clr = stall;

    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC),
        .CNT_W    (CNT_W)
    ) u_md_busy_timer (
        .clk       (clk),
        .reset     (reset),
        .md_start  (md_start),
        .md_is_div (md_is_div),
        .md_busy   (md_busy)
    );

`ifdef STALL_STAT_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
